// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e  : sequencer states
//   REQ_CPU/AUX  : requester indices into req/we/gnt/done
//   req_onehot() : requester index -> one-hot grant/done vector
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   localparam int REQ_CPU = 0;
   localparam int REQ_AUX = 1;

   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, completion,
//            read data and memory drive out)
//   master : requesters plus memory view (the opposite directions)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import mem_arb_pkg::*;

   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt, done, rdata, mem_addr, mem_wr, mem_wdata
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt, done, rdata, mem_addr, mem_wr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
//   req_i         : request vector
//   last_served_i : index of the requester served most recently
//   winner_o      : selected requester index
//   valid_o       : at least one request present
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_served_i,
   output logic       winner_o,
   output logic       valid_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = 1'(REQ_CPU);
      if (req_i == 2'b11) begin
         // tie: whoever was not served last goes next
         winner_o = ~last_served_i;
      end else if (req_i[REQ_AUX]) begin
         winner_o = 1'(REQ_AUX);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and sequencer for a single-port synchronous memory.
// Serialises CPU (requester 0) and aux master (requester 1) accesses, drives
// the registered memory address / write strobe / write data, waits the fixed
// memory latency and returns read data with a one-cycle done pulse.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : req/we/addr/wdata per requester, gnt/done/rdata back,
//                   mem_addr/mem_wr/mem_wdata to memory, mem_rdata from it
//
// state  | meaning
// IDLE   | no transaction; sample req, latch winner's operands
// ACCESS | address/data on memory, mem_wr high for a write
// WAIT   | count down MEM_LATENCY; capture mem_rdata on the last count
// RESP   | done pulse to owner, update round-robin history
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_lat_range
      $error("MEM_LATENCY out of range 1..7");
   end

   arb_state_e        state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_wr_q, mem_wr_d;
   logic              op_we_q, op_we_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              pick_winner;
   logic              pick_valid;

   rr_pick2 u_pick (
      .req_i         (bus.req),
      .last_served_i (last_q),
      .winner_o      (pick_winner),
      .valid_o       (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_d    = 1'b0;
      op_we_d     = op_we_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_valid) begin
               owner_d     = pick_winner;
               op_we_d     = bus.we[pick_winner];
               mem_addr_d  = (pick_winner == 1'(REQ_AUX)) ? bus.addr1 : bus.addr0;
               mem_wdata_d = (pick_winner == 1'(REQ_AUX)) ? bus.wdata1 : bus.wdata0;
               // strobe registered here so it is high for exactly the ACCESS cycle
               mem_wr_d    = bus.we[pick_winner];
               gnt_d       = req_onehot(pick_winner);
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            cnt_d   = CNT_W'(MEM_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (!op_we_q) begin
                  rdata_d = bus.mem_rdata;
               end
               done_d  = req_onehot(owner_q);
               state_d = RESP;
            end
         end
         RESP: begin
            last_d  = owner_q;
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_q    <= 1'b0;
         op_we_q     <= 1'b0;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
         op_we_q     <= op_we_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A with MEM_LATENCY=1 behind a small
// registered memory model, instance B with MEM_LATENCY=3 whose mem_rdata is a
// per-cycle stamp so the capture cycle is visible.
module tb_mem_port_arbiter;

   typedef struct {
      logic [1:0]  who;
      logic        rd;
      logic [31:0] val;
   } exp_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   cyc    = 0;
   int   total  = 0;
   int   bad    = 0;
   int   wr_cnt_a = 0;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t ea, eb;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (a_if.slave)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (b_if.slave)
   );

   // memory A: one-cycle registered read, write on mem_wr
   logic [31:0]  mem_a [0:255];
   logic [255:0] wr_a = '0;

   function automatic logic [31:0] init_val(input logic [7:0] a);
      case (a)
         8'h10:   return 32'hDEAD_BEEF;
         8'h99:   return 32'h9999_9999;
         default: return {24'hA5A5A5, a};
      endcase
   endfunction

   always @(posedge clk_i) begin
      if (a_if.mem_wr) begin
         mem_a[a_if.mem_addr[7:0]] <= a_if.mem_wdata;
         wr_a[a_if.mem_addr[7:0]]  <= 1'b1;
      end
      a_if.mem_rdata <= wr_a[a_if.mem_addr[7:0]] ? mem_a[a_if.mem_addr[7:0]]
                                                 : init_val(a_if.mem_addr[7:0]);
   end

   assign b_if.mem_rdata = {16'hC0DE, cyc[15:0]};

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni) begin
         check_eq("a_gnt_1hot", 64'($onehot0(a_if.gnt)), 64'd1);
         if (a_if.mem_wr) wr_cnt_a = wr_cnt_a + 1;
         if (a_if.done != 2'b00) begin
            if (sb_a.size() == 0) begin
               check_eq("a_spurious_done", 64'(a_if.done), 64'd0);
            end else begin
               ea = sb_a.pop_front();
               check_eq("a_done_who", 64'(a_if.done), 64'(ea.who));
               check_eq("a_gnt_at_done", 64'(a_if.gnt), 64'(ea.who));
               if (ea.rd) check_eq("a_rdata", 64'(a_if.rdata), 64'(ea.val));
            end
         end
         if (b_if.done != 2'b00) begin
            if (sb_b.size() == 0) begin
               check_eq("b_spurious_done", 64'(b_if.done), 64'd0);
            end else begin
               eb = sb_b.pop_front();
               check_eq("b_done_who", 64'(b_if.done), 64'(eb.who));
               if (eb.rd) check_eq("b_rdata", 64'(b_if.rdata), 64'(eb.val));
            end
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_done_a(input logic [1:0] mask, output int c);
      c = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if ((a_if.done & mask) != 2'b00) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) check_eq("a_done_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done_b(input logic [1:0] mask, output int c);
      c = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if ((b_if.done & mask) != 2'b00) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) check_eq("b_done_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_reset_a(input string tag);
      check_eq({tag, "_gnt"},   64'(a_if.gnt),       64'd0);
      check_eq({tag, "_done"},  64'(a_if.done),      64'd0);
      check_eq({tag, "_rdata"}, 64'(a_if.rdata),     64'd0);
      check_eq({tag, "_maddr"}, 64'(a_if.mem_addr),  64'd0);
      check_eq({tag, "_mwd"},   64'(a_if.mem_wdata), 64'd0);
      check_eq({tag, "_mwr"},   64'(a_if.mem_wr),    64'd0);
   endtask

   int t0, c, c2, prev, w0;
   logic [1:0] g_exp [5];
   logic [1:0] d_exp [5];
   logic [15:0] stamp;

   initial begin
      a_if.req = '0; a_if.we = '0; a_if.addr0 = '0; a_if.addr1 = '0;
      a_if.wdata0 = '0; a_if.wdata1 = '0;
      b_if.req = '0; b_if.we = '0; b_if.addr0 = '0; b_if.addr1 = '0;
      b_if.wdata0 = '0; b_if.wdata1 = '0;
      g_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
      d_exp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};

      repeat (3) @(posedge clk_i);
      #1;
      check_reset_a("rst_in");
      check_eq("rst_in_b_gnt", 64'(b_if.gnt), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_reset_a("rst_out");

      // tie held for four transactions: CPU, aux, CPU, aux
      next_cyc();
      t0 = cyc;
      a_if.req = 2'b11; a_if.we = 2'b00; a_if.addr0 = 32'h0; a_if.addr1 = 32'h4;
      for (int i = 0; i < 4; i++)
         sb_a.push_back('{who: (i % 2 == 0) ? 2'b01 : 2'b10, rd: 1'b1,
                          val: init_val((i % 2 == 0) ? 8'h00 : 8'h04)});
      prev = t0;
      for (int i = 0; i < 4; i++) begin
         wait_done_a(2'b11, c);
         check_eq("tie_spacing", 64'(c - prev), (i == 0) ? 64'd3 : 64'd4);
         prev = c;
      end
      next_cyc();
      a_if.req = 2'b00;

      // single CPU read, cycle by cycle
      w0 = wr_cnt_a;
      next_cyc();
      a_if.req = 2'b01; a_if.we = 2'b00; a_if.addr0 = 32'h10;
      sb_a.push_back('{who: 2'b01, rd: 1'b1, val: 32'hDEAD_BEEF});
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            @(posedge clk_i);
            #1;
            a_if.req = 2'b00;
         end
         @(negedge clk_i);
         check_eq("rd_gnt", 64'(a_if.gnt), 64'(g_exp[k]));
         check_eq("rd_done", 64'(a_if.done), 64'(d_exp[k]));
      end
      check_eq("rd_no_wr", 64'(wr_cnt_a - w0), 64'd0);

      // aux write, then CPU reads it back
      w0 = wr_cnt_a;
      next_cyc();
      t0 = cyc;
      a_if.req = 2'b10; a_if.we = 2'b10; a_if.addr1 = 32'h20; a_if.wdata1 = 32'h1234_5678;
      sb_a.push_back('{who: 2'b10, rd: 1'b1, val: 32'hDEAD_BEEF});
      wait_done_a(2'b10, c);
      check_eq("wr_latency", 64'(c - t0), 64'd3);
      next_cyc();
      a_if.req = 2'b00; a_if.we = 2'b00;
      check_eq("wr_once", 64'(wr_cnt_a - w0), 64'd1);
      check_eq("wr_mwdata_held", 64'(a_if.mem_wdata), 64'h1234_5678);
      next_cyc();
      t0 = cyc;
      a_if.req = 2'b01; a_if.addr0 = 32'h20;
      sb_a.push_back('{who: 2'b01, rd: 1'b1, val: 32'h1234_5678});
      wait_done_a(2'b01, c);
      check_eq("rdback_latency", 64'(c - t0), 64'd3);
      next_cyc();
      a_if.req = 2'b00;

      // address changes during WAIT are ignored
      next_cyc();
      t0 = cyc;
      a_if.req = 2'b01; a_if.addr0 = 32'h10;
      sb_a.push_back('{who: 2'b01, rd: 1'b1, val: 32'hDEAD_BEEF});
      next_cyc();
      next_cyc();
      a_if.addr0 = 32'h99;
      @(negedge clk_i);
      check_eq("chg_mem_addr", 64'(a_if.mem_addr), 64'h10);
      wait_done_a(2'b01, c);
      check_eq("chg_latency", 64'(c - t0), 64'd3);
      next_cyc();
      a_if.req = 2'b00; a_if.addr0 = 32'h10;

      // reset in WAIT aborts with no done
      next_cyc();
      a_if.req = 2'b01; a_if.addr0 = 32'h20;
      next_cyc();
      next_cyc();
      rst_ni = 1'b0;
      a_if.req = 2'b00;
      @(negedge clk_i);
      check_reset_a("rst_mid");
      next_cyc();
      rst_ni = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         check_eq("rst_mid_no_done", 64'(a_if.done), 64'd0);
      end

      // first tie after reset goes to CPU again
      next_cyc();
      t0 = cyc;
      a_if.req = 2'b11; a_if.addr0 = 32'h0; a_if.addr1 = 32'h4;
      sb_a.push_back('{who: 2'b01, rd: 1'b1, val: init_val(8'h00)});
      sb_a.push_back('{who: 2'b10, rd: 1'b1, val: init_val(8'h04)});
      wait_done_a(2'b01, c);
      check_eq("post_rst_tie_lat", 64'(c - t0), 64'd3);
      next_cyc();
      a_if.req = 2'b10;
      wait_done_a(2'b10, c2);
      check_eq("post_rst_tie_gap", 64'(c2 - c), 64'd4);
      next_cyc();
      a_if.req = 2'b00;

      // latency 3: capture in cycle 4 of the transaction, done in cycle 5
      next_cyc();
      t0 = cyc;
      stamp = 16'(t0 + 4);
      b_if.req = 2'b01; b_if.we = 2'b00; b_if.addr0 = 32'h40;
      sb_b.push_back('{who: 2'b01, rd: 1'b1, val: {16'hC0DE, stamp}});
      wait_done_b(2'b01, c);
      check_eq("b_latency", 64'(c - t0), 64'd5);
      check_eq("b_gnt_at_done", 64'(b_if.gnt), 64'd1);
      next_cyc();
      b_if.req = 2'b00;

      repeat (4) @(negedge clk_i);
      check_eq("a_sb_empty", 64'(sb_a.size()), 64'd0);
      check_eq("b_sb_empty", 64'(sb_b.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
